// File: rtl/pixel_tone_adjust.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_tone_adjust
//  Purpose  : Brightness/contrast adjuster for a packed multi-channel pixel
//             stream. Three debounced keys (mode/up/down) edit working
//             settings. These settings are copied to applied (shadow) settings
//             only at a frame start, so a frame never tears. Pixels pass
//             through a fixed 3-stage pipeline. Sync and enable are delayed
//             by the same 3 cycles.
//  Ports    : clk, rst                 - pixel clock, sync active-high reset
//             Vsync, Hsync, De, RGB    - input timing and pixel
//             key1, key2, key3         - async keys (mode, up, down), 1 = pressed
//             Vsync_o, Hsync_o, De_o   - timing delayed 3 cycles
//             RGB_o                    - adjusted pixel, 3-cycle latency
//             mode_o, bright_o,
//             contrast_o               - working settings
//  Revision : 1.0  initial release
// ============================================================================
module pixel_tone_adjust #(
    parameter int CW      = 8,
    parameter int NCH     = 3,
    parameter int STEP    = 10,
    parameter int BMAX    = 70,
    parameter int CMAX    = 70,
    parameter int DEB_CYC = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Vsync,
    input  logic                Hsync,
    input  logic                De,
    input  logic [NCH*CW-1:0]   RGB,
    input  logic                key1,
    input  logic                key2,
    input  logic                key3,
    output logic                Vsync_o,
    output logic                Hsync_o,
    output logic                De_o,
    output logic [NCH*CW-1:0]   RGB_o,
    output logic [1:0]          mode_o,
    output logic [7:0]          bright_o,
    output logic [7:0]          contrast_o
);

    localparam int c_CNT_W = $clog2(DEB_CYC);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_CYC - 1);
    localparam logic signed [CW+9:0] c_MID_EXT = (CW+10)'(2 ** (CW - 1));

    typedef enum logic [1:0] {
        MODE_BYPASS   = 2'd0,
        MODE_BRIGHT   = 2'd1,
        MODE_CONTRAST = 2'd2,
        MODE_RSVD     = 2'd3
    } mode_t;

    // ------------------------------------------------------------------
    // Key front end: 2-FF synchroniser, stability counter, press pulse
    // ------------------------------------------------------------------
    logic [2:0] w_keys;
    logic [2:0] w_press;

    assign w_keys = {key3, key2, key1};

    genvar gk;
    generate
        for (gk = 0; gk < 3; gk++) begin : g_key
            logic               r_s1;
            logic               r_s2;
            logic               r_s2_d;
            logic               r_deb;
            logic               r_deb_d;
            logic [c_CNT_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1    <= 1'b0;
                    r_s2    <= 1'b0;
                    r_s2_d  <= 1'b0;
                    r_deb   <= 1'b0;
                    r_deb_d <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_s1    <= w_keys[gk];
                    r_s2    <= r_s1;
                    r_s2_d  <= r_s2;
                    r_deb_d <= r_deb;
                    // The counter restarts on every change of the synchronised
                    // level and then saturates at its last value. While it
                    // holds that value, the debounced level follows the input.
                    if (r_s2 != r_s2_d) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_deb <= r_s2;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_press[gk] = r_deb & ~r_deb_d;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Working mode and levels
    // ------------------------------------------------------------------
    mode_t       r_mode;
    logic [7:0]  r_bright;
    logic [7:0]  r_contrast;
    logic [8:0]  w_b_sum;
    logic [8:0]  w_c_sum;
    logic [7:0]  w_b_inc;
    logic [7:0]  w_c_inc;
    logic [7:0]  w_b_dec;
    logic [7:0]  w_c_dec;

    assign w_b_sum = {1'b0, r_bright}   + 9'(STEP);
    assign w_c_sum = {1'b0, r_contrast} + 9'(STEP);
    assign w_b_inc = (w_b_sum > 9'(BMAX)) ? 8'd0 : w_b_sum[7:0];
    assign w_c_inc = (w_c_sum > 9'(CMAX)) ? 8'd0 : w_c_sum[7:0];
    assign w_b_dec = (r_bright   < 8'(STEP)) ? 8'd0 : r_bright   - 8'(STEP);
    assign w_c_dec = (r_contrast < 8'(STEP)) ? 8'd0 : r_contrast - 8'(STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode     <= MODE_BYPASS;
            r_bright   <= 8'd0;
            r_contrast <= 8'd0;
        end else begin
            // Level edits look at the current mode. A mode key press in the
            // same cycle therefore does not redirect the edit. Up and down
            // pressed together cancel each other.
            if (w_press[1] && !w_press[2]) begin
                case (r_mode)
                    MODE_BRIGHT:   r_bright   <= w_b_inc;
                    MODE_CONTRAST: r_contrast <= w_c_inc;
                    default: ;
                endcase
            end else if (w_press[2] && !w_press[1]) begin
                case (r_mode)
                    MODE_BRIGHT:   r_bright   <= w_b_dec;
                    MODE_CONTRAST: r_contrast <= w_c_dec;
                    default: ;
                endcase
            end

            case (r_mode)
                MODE_BYPASS:   if (w_press[0]) r_mode <= MODE_BRIGHT;
                MODE_BRIGHT:   if (w_press[0]) r_mode <= MODE_CONTRAST;
                MODE_CONTRAST: if (w_press[0]) r_mode <= MODE_BYPASS;
                default:       r_mode <= MODE_BYPASS;
            endcase
        end
    end

    assign mode_o     = r_mode;
    assign bright_o   = r_bright;
    assign contrast_o = r_contrast;

    // ------------------------------------------------------------------
    // Shadow (applied) settings, loaded one cycle after the Vsync rise is
    // detected. Any edit that lands on the detect cycle is still captured.
    // ------------------------------------------------------------------
    logic        r_vs;
    logic        r_load;
    mode_t       r_sh_mode;
    logic [7:0]  r_sh_b;
    logic [7:0]  r_sh_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs      <= 1'b0;
            r_load    <= 1'b0;
            r_sh_mode <= MODE_BYPASS;
            r_sh_b    <= 8'd0;
            r_sh_c    <= 8'd0;
        end else begin
            r_vs   <= Vsync;
            r_load <= Vsync & ~r_vs;
            if (r_load) begin
                r_sh_mode <= r_mode;
                r_sh_b    <= r_bright;
                r_sh_c    <= r_contrast;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline. The applied settings travel with each pixel, so a
    // shadow load never affects a pixel that is already in flight.
    // ------------------------------------------------------------------
    logic [NCH*CW-1:0] r1_x;
    logic [NCH*CW-1:0] r2_x;
    mode_t             r1_mode;
    mode_t             r2_mode;
    logic [7:0]        r1_b;
    logic [7:0]        r2_b;
    logic [7:0]        r1_c;
    logic [2:0]        r1_sync;
    logic [2:0]        r2_sync;
    logic [2:0]        r3_sync;
    logic [NCH*CW-1:0] w_rgb_y;
    logic              w_r2_adjust;

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_x    <= '0;
            r2_x    <= '0;
            r1_mode <= MODE_BYPASS;
            r2_mode <= MODE_BYPASS;
            r1_b    <= 8'd0;
            r2_b    <= 8'd0;
            r1_c    <= 8'd0;
            r1_sync <= 3'b000;
            r2_sync <= 3'b000;
            r3_sync <= 3'b000;
        end else begin
            r1_x    <= RGB;
            r1_mode <= r_sh_mode;
            r1_b    <= r_sh_b;
            r1_c    <= r_sh_c;
            r1_sync <= {Vsync, Hsync, De};
            r2_x    <= r1_x;
            r2_mode <= r1_mode;
            r2_b    <= r1_b;
            r2_sync <= r1_sync;
            r3_sync <= r2_sync;
        end
    end

    assign w_r2_adjust = (r2_mode == MODE_BRIGHT) || (r2_mode == MODE_CONTRAST);

    genvar gc;
    generate
        for (gc = 0; gc < NCH; gc++) begin : g_ch
            logic        [CW-1:0] w_x;
            logic signed [CW:0]   w_d;
            logic signed [CW:0]   r1_d;
            logic signed [9:0]    w_gain;
            logic signed [CW+9:0] w_p;
            logic signed [CW+9:0] r2_p;
            logic signed [CW+9:0] w_q;
            logic        [CW-1:0] w_clamp;
            logic        [CW-1:0] r3_y;

            assign w_x    = RGB[gc*CW +: CW];
            // Offset-binary to signed, centred on mid-grey
            assign w_d    = $signed({1'b0, w_x}) - $signed({2'b01, {(CW-1){1'b0}}});
            // Gain is (64 + C) / 64 and always positive
            assign w_gain = $signed({2'b00, r1_c}) + 10'sd64;
            assign w_p    = (CW+10)'(r1_d) * (CW+10)'(w_gain);
            assign w_q    = (r2_p >>> 6) + c_MID_EXT + $signed({{(CW+2){1'b0}}, r2_b});

            always_comb begin
                w_clamp = w_q[CW-1:0];
                if (w_q[CW+9]) begin
                    w_clamp = '0;
                end else if (|w_q[CW+8:CW]) begin
                    w_clamp = '1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r1_d <= '0;
                    r2_p <= '0;
                    r3_y <= '0;
                end else begin
                    r1_d <= w_d;
                    r2_p <= w_p;
                    r3_y <= w_r2_adjust ? w_clamp : r2_x[gc*CW +: CW];
                end
            end

            assign w_rgb_y[gc*CW +: CW] = r3_y;
        end
    endgenerate

    assign RGB_o                   = w_rgb_y;
    assign {Vsync_o, Hsync_o, De_o} = r3_sync;

endmodule
`default_nettype wire
